z_cba_reg_adder: RTL and testbench
==================================

// Module: z_cba_reg_adder
// PURPOSE
// - Registered WIDTH-bit carry-bypass (carry-skip) adder.
// - Per-bit setup cells make propagate/generate; per-bit full-adder cells ripple inside each BLOCK-bit group.
// - A bypass mux lets each group's carry-in skip to its carry-out when every bit in the group propagates.
// - Datapath arithmetic unit; result is registered one clock after the operands are accepted.
// PARAMETERS
// - WIDTH  default 16  operand/sum width; must be a multiple of BLOCK and >= BLOCK
// - BLOCK  default 4   bits per bypass group
// PORTS
// - clk        input   1      rising-edge clock (the only clock)
// - rst_n      input   1      asynchronous, active-low reset
// - in_valid   input   1      operands valid this cycle; capture result on next rising edge
// - a          input   WIDTH  operand A, unsigned
// - b          input   WIDTH  operand B, unsigned
// - c_in       input   1      carry into bit 0
// - sum        output  WIDTH  registered (a + b + c_in) mod 2^WIDTH
// - c_out      output  1      registered carry out of bit WIDTH-1
// - p_all      output  1      registered AND of all per-bit propagates (a ^ b == all ones)
// - out_valid  output  1      registered copy of in_valid
// BEHAVIOUR
// - Reset (rst_n low, asynchronous, no clock needed):
//   - sum=0, c_out=0, p_all=0, out_valid=0.
//   - Outputs stay at these values while rst_n is low.
// - Setup cell per bit i: prop[i] = a[i] ^ b[i]; gen[i] = a[i] & b[i].
// - Full-adder cell per bit i:
//   - s[i] = prop[i] ^ ci[i]
//   - co[i] = gen[i] | (prop[i] & ci[i])
//   - p[i] = prop[i] (pass-through propagate)
// - Group k (bits k*BLOCK .. k*BLOCK+BLOCK-1), with group carry-in gcin[k]:
//   - gcin[0] = c_in; bits ripple inside the group.
//   - gcout[k] = ripple_co[k] | (&p[group k] & gcin[k]).
//   - gcin[k+1] = gcout[k].
// - Bypass correctness: the bypass term MUST be qualified by gcin[k].
//   - An all-propagate group with gcin=0 produces gcout=0, never 1.
// - The combinational result must equal a + b + c_in for every input.
//   - The bypass only shortens the critical path; it never changes the value.
// - Clocking, at each rising clk edge with rst_n high:
//   - If in_valid=1: sum, c_out, p_all load the combinational result; out_valid <= 1.
//   - If in_valid=0: sum, c_out, p_all hold their values; out_valid <= 0.
// - Latency: exactly 1 clock from in_valid sample to out_valid=1 with the matching result.
//   - Back-to-back valid inputs give back-to-back results; no stalls, no backpressure.
// - Overflow: sum wraps modulo 2^WIDTH; the carry appears only on c_out. No saturation.
// - Reset asserted mid-stream:
//   - The in-flight result is discarded and outputs clear immediately.
//   - After rst_n deasserts, the first valid result appears one edge after the first sampled in_valid=1.
// - No X propagation from held outputs: registers change only on a valid edge or on reset.
// TESTING (WIDTH=16, BLOCK=4)
// - Reset: rst_n=0 mid-cycle -> sum=0x0000, c_out=0, p_all=0, out_valid=0 immediately, without a clock edge.
// - Plain add: a=0x1234, b=0x4321, c_in=0, in_valid=1
//   -> next edge: sum=0x5555, c_out=0, p_all=0, out_valid=1.
// - Full bypass with carry: a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, c_out=1, p_all=1.
// - Full bypass without carry: a=0xFFFF, b=0x0000, c_in=0 -> sum=0xFFFF, c_out=0, p_all=1.
//   - This case catches an unqualified bypass term.
// - Generate/overflow: a=0x8000, b=0x8000, c_in=0 -> sum=0x0000, c_out=1.
//   - Then a=0x00F0, b=0x0010, c_in=0 -> sum=0x0100, c_out=0 (carry crosses a group boundary).
// - Hold and random check:
//   - Drop in_valid for 3 cycles -> sum/c_out hold, out_valid=0.
//   - Then 1000 random a/b/c_in values checked against a 17-bit reference sum.

Source files
------------

// File: rtl/z_cba_reg_adder.sv
// z_cba_reg_adder: registered carry-bypass adder with one-cycle latency
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid            operands valid; result captured on next rising edge
//   a, b, c_in          unsigned operands and carry into bit 0
//   sum, c_out          registered (a + b + c_in) and carry out of the top bit
//   p_all               registered &(a ^ b)
//   out_valid           registered copy of in_valid
module z_cba_reg_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             p_all,
    output logic             out_valid
);
    localparam int NG = WIDTH / BLOCK;
    logic [WIDTH-1:0] prop, gen, ci, co, s;
    logic [NG:0]      gc;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d, p_all_q, p_all_d, out_valid_q;
    assign prop  = a ^ b;
    assign gen   = a & b;
    assign gc[0] = c_in;
    for (genvar g = 0; g < NG; g++) begin : grp
        for (genvar j = 0; j < BLOCK; j++) begin : fa
            if (j == 0) begin : first
                assign ci[g*BLOCK+j] = gc[g];
            end else begin : rest
                assign ci[g*BLOCK+j] = co[g*BLOCK+j-1];
            end
            assign s[g*BLOCK+j]  = prop[g*BLOCK+j] ^ ci[g*BLOCK+j];
            assign co[g*BLOCK+j] = gen[g*BLOCK+j] | (prop[g*BLOCK+j] & ci[g*BLOCK+j]);
        end
        // skip path must be gated by the group carry-in, or an all-propagate group would invent a carry
        assign gc[g+1] = co[g*BLOCK+BLOCK-1] | (&prop[g*BLOCK +: BLOCK] & gc[g]);
    end
    always_comb begin
        sum_d   = in_valid ? s : sum_q;
        c_out_d = in_valid ? gc[NG] : c_out_q;
        p_all_d = in_valid ? &prop : p_all_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            p_all_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            p_all_q     <= p_all_d;
            out_valid_q <= in_valid;
        end
    end
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign p_all     = p_all_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_z_cba_reg_adder.sv
// tb_z_cba_reg_adder: directed vectors, hold, random and reset checks for z_cba_reg_adder
module tb_z_cba_reg_adder;
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] s;
        logic        co;
        logic        pa;
    } vec_t;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, c_in = 1'b0;
    logic [15:0] a = '0, b = '0, sum;
    logic        c_out, p_all, out_valid;
    int          total = 0, bad = 0;
    vec_t        vecs[8];
    z_cba_reg_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c_in(c_in),
        .sum(sum), .c_out(c_out), .p_all(p_all), .out_valid(out_valid)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [15:0] s, input logic co, input logic pa, input logic ov);
        total++;
        if ({sum, c_out, p_all, out_valid} !== {s, co, pa, ov}) begin
            bad++;
            $display("FAIL %s: got sum=%h c_out=%b p_all=%b out_valid=%b, want sum=%h c_out=%b p_all=%b out_valid=%b",
                     nm, sum, c_out, p_all, out_valid, s, co, pa, ov);
        end
    endtask
    task automatic apply(input logic [15:0] x, input logic [15:0] y, input logic c, input logic v);
        @(negedge clk);
        a = x; b = y; c_in = c; in_valid = v;
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [15:0] ra, rb, hs;
        logic        rc, hc, hp;
        logic [16:0] ref_sum;
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[6] = '{16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
        #3;
        chk("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].c, 1'b1);
            chk($sformatf("vec%0d", i), vecs[i].s, vecs[i].co, vecs[i].pa, 1'b1);
        end
        hs = vecs[7].s; hc = vecs[7].co; hp = vecs[7].pa;
        for (int i = 0; i < 3; i++) begin
            apply(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
            chk($sformatf("hold%0d", i), hs, hc, hp, 1'b0);
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            ref_sum = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
            apply(ra, rb, rc, 1'b1);
            chk($sformatf("rand%0d a=%h b=%h c=%b", i, ra, rb, rc), ref_sum[15:0], ref_sum[16], &(ra ^ rb), 1'b1);
        end
        apply(16'h1234, 16'h4321, 1'b0, 1'b1);
        chk("pre_rst", 16'h5555, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; c_in = 1'b1; in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_hold", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        a = 16'h8000; b = 16'h8000; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst", 16'h0000, 1'b1, 1'b0, 1'b1);
        apply(16'h00F0, 16'h0010, 1'b0, 1'b0);
        chk("post_rst_drop", 16'h0000, 1'b1, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
